// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, reset vector and
// address-field geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_LOOKUP,
    ST_REQ,
    ST_FILL,
    ST_FLUSH
  } state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hFFFF_0000;

  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_WORD_BITS   = 2;
  localparam int DEF_OFFSET_BITS = 2 + DEF_WORD_BITS;
  localparam int DEF_TAG_BITS    = 32 - DEF_OFFSET_BITS - DEF_INDEX_BITS;

  function automatic int tag_bits(input int index_bits, input int word_bits);
    return 32 - 2 - word_bits - index_bits;
  endfunction

endpackage

// File: rtl/cpu_icache_ram.sv
// Single-port RAM with registered read; a write and a read share the address,
// and the read returns the old contents.
module cpu_icache_ram #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 we_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hit latency, burst line
// fill with critical-word bypass, and a sequential valid-bit flush sweep.
module cpu_icache
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_BITS   = 2 + WORD_BITS;
  localparam int TAG_BITS   = tag_bits(INDEX_BITS, WORD_BITS);
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int WORDS      = 1 << WORD_BITS;
  localparam int DADDR_BITS = INDEX_BITS + WORD_BITS;
  localparam int TAG_LSB    = OFF_BITS + INDEX_BITS;

  state_e                state_q;
  logic [31:2]           req_addr_q;
  logic [LINES-1:0]      valid_q;
  logic [WORD_BITS-1:0]  beat_q;
  logic [INDEX_BITS-1:0] sweep_q;
  logic                  flush_pend_q;
  logic                  bypass_q;
  logic [31:0]           bypass_data_q;
  logic                  mem_req_q;
  logic [31:0]           mem_addr_q;

  logic [TAG_BITS-1:0]   req_tag;
  logic [TAG_BITS-1:0]   tag_rdata;
  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] tag_addr;
  logic [WORD_BITS-1:0]  req_word;
  logic [DADDR_BITS-1:0] data_addr;
  logic [31:0]           data_rdata;
  logic                  hit, serve, accept, fill_beat, last_beat;

  assign req_tag  = req_addr_q[31:TAG_LSB];
  assign req_idx  = req_addr_q[TAG_LSB-1:OFF_BITS];
  assign req_word = req_addr_q[OFF_BITS-1:2];

  // The RAM read of the previous cycle always targets req_addr_q, so the
  // lookup compares against the registered address.
  assign hit       = valid_q[req_idx] && (tag_rdata == req_tag);
  assign serve     = (state_q == ST_LOOKUP) && (bypass_q || hit);
  assign stall     = !reset && !serve;
  assign accept    = !stall;
  assign fill_beat = (state_q == ST_FILL) && mem_rvalid;
  assign last_beat = fill_beat && (beat_q == WORD_BITS'(WORDS - 1));

  always_comb begin
    data_addr = req_addr_q[TAG_LSB-1:2];
    tag_addr  = req_idx;
    if (fill_beat) begin
      data_addr = {req_idx, beat_q};
    end else if (accept) begin
      data_addr = instr_addr[TAG_LSB-1:2];
      tag_addr  = instr_addr[TAG_LSB-1:OFF_BITS];
    end
  end

  cpu_icache_ram #(.WIDTH(32), .DEPTH(1 << DADDR_BITS)) u_data_ram (
    .clock   (clock),
    .addr_i  (data_addr),
    .we_i    (fill_beat),
    .wdata_i (mem_rdata),
    .rdata_o (data_rdata)
  );

  cpu_icache_ram #(.WIDTH(TAG_BITS), .DEPTH(LINES)) u_tag_ram (
    .clock   (clock),
    .addr_i  (tag_addr),
    .we_i    (last_beat),
    .wdata_i (req_tag),
    .rdata_o (tag_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_LOOKUP;
      req_addr_q   <= instr_addr[31:2];
      valid_q      <= '0;
      beat_q       <= '0;
      sweep_q      <= '0;
      flush_pend_q <= 1'b0;
      bypass_q     <= 1'b0;
      bypass_data_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      bypass_q <= 1'b0;
      if (accept) begin
        req_addr_q <= instr_addr[31:2];
      end
      // A flush arriving mid-fill waits until the line is complete.
      if (flush && (state_q == ST_REQ || state_q == ST_FILL)) begin
        flush_pend_q <= 1'b1;
      end
      case (state_q)
        ST_LOOKUP: begin
          if (flush || flush_pend_q) begin
            state_q      <= ST_FLUSH;
            sweep_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (!serve) begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {req_addr_q[31:OFF_BITS], {OFF_BITS{1'b0}}};
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q   <= ST_FILL;
            mem_req_q <= 1'b0;
            beat_q    <= '0;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == req_word) begin
              bypass_data_q <= mem_rdata;
            end
            if (last_beat) begin
              valid_q[req_idx] <= 1'b1;
              bypass_q         <= 1'b1;
              state_q          <= ST_LOOKUP;
            end
          end
        end
        default: begin
          valid_q[sweep_q] <= 1'b0;
          sweep_q          <= sweep_q + 1'b1;
          if (sweep_q == INDEX_BITS'(LINES - 1)) begin
            state_q <= ST_LOOKUP;
          end
        end
      endcase
    end
  end

  assign instr_data = reset ? '0 : (bypass_q ? bypass_data_q : data_rdata);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: doc/cpu_icache.md
Name: cpu_icache

Overview:
- Instruction-side responder for the CPU fetch stage.
- Accepts the fetch address each cycle and returns the 32-bit instruction word one cycle later.
- Direct-mapped, read-only cache; line fills come from a burst memory port.
- On a miss, raises `stall` until the line is resident, then delivers the word and releases the pipeline.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines)
- WORD_BITS, 2, log2 of words per line (4 words = 16 bytes)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr_addr  in  32  fetch address from PC unit (byte address, bits [1:0] ignored)
- instr_data  out  32  instruction word for the address presented on the previous accepted cycle
- stall  out  1  high while the previous-cycle address is not yet served
- flush  in  1  one-cycle pulse: invalidate all lines
- mem_req  out  1  line-fill request, held until `mem_ack`
- mem_addr  out  32  line-aligned fill address (low 2+WORD_BITS bits zero)
- mem_ack  in  1  memory accepted request
- mem_rvalid  in  1  one fill beat valid
- mem_rdata  in  32  fill beat data, words in ascending address order

Behaviour:
- Interface rule: reset is `reset`, synchronous, active-high; clock is `clock`.
- Address split:
  - tag = addr[31:2+WORD_BITS+INDEX_BITS]
  - index = next INDEX_BITS bits
  - word = addr[2+WORD_BITS-1:2]
- Storage:
  - Data RAM: synchronous read, 2^(INDEX_BITS+WORD_BITS) x 32.
  - Tag RAM and valid bits: per line.
- States: LOOKUP, REQ, FILL, FLUSH.
- LOOKUP:
  - Every cycle with `stall`=0, register `instr_addr` as `req_addr` and read data/tag RAM at its index.
  - Next cycle, hit = valid[idx] && tag match.
  - On hit: `instr_data` = RAM output, `stall`=0, the new `instr_addr` is accepted. Back-to-back hits give 1 word/cycle.
  - On miss: `stall`=1 combinationally in the same cycle, go to REQ. `instr_addr` is ignored while `stall`=1, so a garbage address from the fetch unit is harmless.
- REQ:
  - `mem_req`=1, `mem_addr` = `req_addr` line-aligned.
  - On `mem_ack`, go to FILL with beat counter = 0.
- FILL:
  - Each `mem_rvalid` writes `mem_rdata` to data RAM at {index, counter} and increments the counter.
  - If counter == word(`req_addr`), also capture the beat into a bypass register.
  - After the last beat: write tag, set valid, return to LOOKUP.
  - In the cycle after the last beat: `stall`=0, `instr_data` = bypass register, `instr_addr` accepted.
  - Miss penalty = REQ wait + 2^WORD_BITS beats + 1 cycle.
- FLUSH:
  - Clears one valid bit per cycle, index 0..2^INDEX_BITS-1, with `stall`=1 throughout.
  - Then returns to LOOKUP and re-looks up `req_addr`; that lookup misses.
  - A `flush` during LOOKUP enters FLUSH next cycle. A `flush` during REQ/FILL is latched and taken after the fill completes.
- `stall` is 1 in REQ, FILL and FLUSH, and in LOOKUP on a miss.
- Reset:
  - All valid bits cleared: bulk clear or forced FLUSH sweep; if swept, `stall`=1 until done.
  - State = LOOKUP, `mem_req`=0, `mem_addr`=0, `instr_data`=0, `stall`=0 during reset.
  - `req_addr` is loaded from `instr_addr` during reset, so the reset vector 0xFFFF0000 is fetched first.
- Reset mid-fill: the fill is abandoned and the partial line is left invalid. Beats arriving after reset are ignored until a new `mem_ack`.
- No self-modifying-code coherence; software issues `flush`.

Decomposition:
- Shared package `cpu_pkg`:
  - state encoding (LOOKUP/REQ/FILL/FLUSH)
  - RESET_VECTOR = 32'hFFFF0000
  - address-field width constants derived from INDEX_BITS/WORD_BITS
- Sub-module `cpu_icache_ram`:
  - generic single-port synchronous-read RAM, WIDTH/DEPTH parameters
  - instantiated twice: data (32 wide) and tag (tag-width wide)
- Valid bits stay as flops in `cpu_icache`.

Test Plan:
- Cold start: release reset with `instr_addr`=0xFFFF0000.
  - Expect `stall`=1, `mem_req`=1, `mem_addr`=0xFFFF0000.
  - Ack, then beats 0x11,0x22,0x33,0x44.
  - Expect `stall` falls the cycle after the 4th beat with `instr_data`=0x11.
- Sequential hits: after the cold fill, present 0xFFFF0004, 0xFFFF0008, 0xFFFF000C on consecutive cycles. Expect `instr_data` 0x22, 0x33, 0x44 with `stall`=0 throughout.
- Critical word: miss at 0x0000_1008. Expect `mem_addr`=0x0000_1000 and `instr_data` = third beat when `stall` drops.
- Conflict eviction:
  - Fill 0x0000_0000, then fetch 0x0000_0400 (same index, different tag). Expect a refill.
  - Refetch 0x0000_0000. Expect a miss again.
- Flush: pulse `flush` after a resident hit. Expect `stall` held for 64+ cycles, then a refetch of the same address misses and issues `mem_req`.
- Reset mid-fill: assert reset after 2 of 4 beats. Expect `mem_req`=0, `stall`=0 during reset, and a post-reset fetch of that line misses.
